mem_access_stage: RTL

- Pipeline stage directly downstream of the ALU in the MIPS32 core.
- Takes the registered ALU result as a data-memory address, or as a pass-through result, plus the store operand and a memory-op code.
- Performs word/half/byte loads and stores over a req/ack data-memory handshake.
- Produces the writeback bundle (data, destination register, write enable) and stalls upstream while a memory access is outstanding.

---
 rtl/mem_access_stage.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access pipeline stage that sits directly after the ALU in the
//   MIPS32 core. It passes non-memory results straight to writeback, rejects
//   misaligned accesses, and performs word/half/byte loads and stores over a
//   req/ack data-memory handshake. It stalls upstream (in_ready=0) while an
//   access is outstanding, and aborts an access that waits too long for ack.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready upstream handshake (in_ready is combinational, IDLE only)
//   alu_result          address for memory ops, writeback data for NONE
//   store_data          store operand (rt)
//   mem_op              000 NONE 001 LW 010 LB 011 LBU 100 SW 101 SB 110 LH 111 LHU
//   rd_addr, reg_we_in  destination register and its write enable
//   dmem_*              data-memory request bundle; dmem_ack/dmem_rdata response
//   wb_*                registered one-cycle writeback bundle
//   err_misalign        one-cycle pulse, misaligned access rejected
//   err_timeout         one-cycle pulse, access aborted after TIMEOUT_CYCLES
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  mem_op,
  input  logic [4:0]  rd_addr,
  input  logic        reg_we_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_LB   = 3'b010;
  localparam logic [2:0] OP_LBU  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_SB   = 3'b101;
  localparam logic [2:0] OP_LH   = 3'b110;
  localparam logic [2:0] OP_LHU  = 3'b111;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Word accesses need a 4-byte aligned address, halfword accesses 2-byte.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic bad;
    case (op)
      OP_LW, OP_SW:  bad = (lo != 2'b00);
      OP_LH, OP_LHU: bad = lo[0];
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Little-endian byte lanes touched by the access.
  function automatic logic [3:0] byte_enables(input logic [2:0] op, input logic [1:0] lo);
    logic [3:0] be;
    case (op)
      OP_LW, OP_SW:          be = 4'b1111;
      OP_LH, OP_LHU:         be = lo[1] ? 4'b1100 : 4'b0011;
      OP_LB, OP_LBU, OP_SB:  be = 4'b0001 << lo;
      default:               be = 4'b0000;
    endcase
    return be;
  endfunction

  // Extracts the addressed lane from the read word and sign/zero extends it.
  function automatic logic [31:0] load_value(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (lo)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      2'b11:   b = rdata[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LW:   v = rdata;
      OP_LB:   v = {{24{b[7]}}, b};
      OP_LBU:  v = {24'h000000, b};
      OP_LH:   v = {{16{h[15]}}, h};
      OP_LHU:  v = {16'h0000, h};
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

  state_t      state_r, state_next_s;
  logic [7:0]  cnt_r, cnt_next_s, cnt_inc_s;
  logic [2:0]  op_r;
  logic [1:0]  lane_r;
  logic [4:0]  rd_r;
  logic        reg_we_r;
  logic        timeout_s;
  logic        in_ready_s, pass_s, misalign_s, issue_s, complete_s, abort_s;
  logic        store_r_s;

  logic        dmem_req_r, dmem_we_r;
  logic [31:0] dmem_addr_r, dmem_wdata_r;
  logic [3:0]  dmem_be_r;
  logic        wb_valid_r, wb_we_r, err_misalign_r, err_timeout_r;
  logic [31:0] wb_data_r;
  logic [4:0]  wb_rd_r;

  // Saturating wait counter; the access aborts once the count of ack-less
  // cycles would reach the limit, so an ack in that same cycle still wins.
  assign cnt_inc_s = (cnt_r == 8'hFF) ? 8'hFF : (cnt_r + 8'd1);
  assign timeout_s = (cnt_inc_s >= TIMEOUT_LIMIT);
  assign store_r_s = (op_r == OP_SW) || (op_r == OP_SB);

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'h00;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and next-count logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (complete_s || abort_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
          cnt_next_s   = cnt_inc_s;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: upstream ready plus the event strobes driving the registers.
  always_comb begin
    in_ready_s = 1'b0;
    pass_s     = 1'b0;
    misalign_s = 1'b0;
    issue_s    = 1'b0;
    complete_s = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          if (mem_op == OP_NONE) begin
            pass_s = 1'b1;
          end else if (misaligned(mem_op, alu_result[1:0])) begin
            misalign_s = 1'b1;
          end else begin
            issue_s = 1'b1;
          end
        end else begin
          pass_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          complete_s = 1'b1;
        end else if (timeout_s) begin
          abort_s = 1'b1;
        end else begin
          complete_s = 1'b0;
        end
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Registered memory request, latched access context and writeback bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req_r     <= 1'b0;
      dmem_we_r      <= 1'b0;
      dmem_addr_r    <= 32'h00000000;
      dmem_be_r      <= 4'b0000;
      dmem_wdata_r   <= 32'h00000000;
      op_r           <= OP_NONE;
      lane_r         <= 2'b00;
      rd_r           <= 5'd0;
      reg_we_r       <= 1'b0;
      wb_valid_r     <= 1'b0;
      wb_data_r      <= 32'h00000000;
      wb_rd_r        <= 5'd0;
      wb_we_r        <= 1'b0;
      err_misalign_r <= 1'b0;
      err_timeout_r  <= 1'b0;
    end else begin
      wb_valid_r     <= pass_s | misalign_s | complete_s | abort_s;
      err_misalign_r <= misalign_s;
      err_timeout_r  <= abort_s;

      if (pass_s) begin
        wb_data_r <= alu_result;
        wb_rd_r   <= rd_addr;
        wb_we_r   <= reg_we_in;
      end else if (misalign_s) begin
        wb_data_r <= 32'h00000000;
        wb_rd_r   <= rd_addr;
        wb_we_r   <= 1'b0;
      end else if (complete_s) begin
        wb_rd_r <= rd_r;
        if (store_r_s) begin
          wb_data_r <= 32'h00000000;
          wb_we_r   <= 1'b0;
        end else begin
          wb_data_r <= load_value(op_r, lane_r, dmem_rdata);
          wb_we_r   <= reg_we_r;
        end
      end else if (abort_s) begin
        wb_data_r <= 32'h00000000;
        wb_rd_r   <= rd_r;
        wb_we_r   <= 1'b0;
      end else begin
        // wb_we is only meaningful alongside wb_valid, so drop it between pulses.
        wb_we_r <= 1'b0;
      end

      if (issue_s) begin
        dmem_req_r   <= 1'b1;
        dmem_we_r    <= (mem_op == OP_SW) || (mem_op == OP_SB);
        dmem_addr_r  <= {alu_result[31:2], 2'b00};
        dmem_be_r    <= byte_enables(mem_op, alu_result[1:0]);
        if (mem_op == OP_SB) begin
          dmem_wdata_r <= {4{store_data[7:0]}};
        end else if (mem_op == OP_SW) begin
          dmem_wdata_r <= store_data;
        end else begin
          dmem_wdata_r <= 32'h00000000;
        end
        op_r     <= mem_op;
        lane_r   <= alu_result[1:0];
        rd_r     <= rd_addr;
        reg_we_r <= reg_we_in;
      end else if (complete_s || abort_s) begin
        dmem_req_r <= 1'b0;
        dmem_we_r  <= 1'b0;
      end else begin
        dmem_req_r <= dmem_req_r;
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign dmem_req     = dmem_req_r;
  assign dmem_we      = dmem_we_r;
  assign dmem_addr    = dmem_addr_r;
  assign dmem_be      = dmem_be_r;
  assign dmem_wdata   = dmem_wdata_r;
  assign wb_valid     = wb_valid_r;
  assign wb_data      = wb_data_r;
  assign wb_rd        = wb_rd_r;
  assign wb_we        = wb_we_r;
  assign err_misalign = err_misalign_r;
  assign err_timeout  = err_timeout_r;

endmodule
